ysyx_23060096_wbu: RTL and testbench
====================================

YSYX_23060096_WBU -- requirements
Module: ysyx_23060096_wbu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register-data width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports iss_valid in 1, iss_ready out 1, iss_rd in ADDR_WIDTH: the issue stage announcing a new destination register.
REQ-006 SHALL have ports exu_valid in 1, exu_ready out 1, exu_rd in ADDR_WIDTH, exu_data in DATA_WIDTH: the ALU result.
REQ-007 SHALL have ports lsu_valid in 1, lsu_ready out 1, lsu_rd in ADDR_WIDTH, lsu_data in DATA_WIDTH: the load result.
REQ-008 SHALL have ports rf_wen out 1, rf_waddr out ADDR_WIDTH, rf_wdata out DATA_WIDTH: the register-file write port.
REQ-009 SHALL have ports chk_ra in ADDR_WIDTH, chk_rb in ADDR_WIDTH, busy_a out 1, busy_b out 1: the hazard query.

Function
REQ-010 SHALL accept a transfer on any port only when valid and ready are both high at the posedge.
REQ-011 SHALL hold lsu_ready at 1 at all times.
REQ-012 SHALL drive exu_ready as !lsu_valid, so LSU wins when both ports present a result in the same cycle.
REQ-013 SHALL register the accepted result: an accept at cycle N gives rf_wen=1, rf_waddr=rd, rf_wdata=data in cycle N+1 only.
REQ-014 SHALL keep rf_wen=0 in any cycle that follows a cycle with no accept.
REQ-015 SHALL accept a result with rd=0 but SHALL NOT assert rf_wen for it or change any counter.
REQ-016 SHALL keep a 2-bit pending counter for each register 1..2^ADDR_WIDTH-1; x0 has no counter.
REQ-017 SHALL increment pending[iss_rd] on an issue accept with iss_rd!=0.
REQ-018 SHALL decrement pending[rf_waddr] at the posedge that ends a cycle with rf_wen=1.
REQ-019 SHALL leave the counter unchanged when an increment and a decrement hit the same register in the same cycle.
REQ-020 SHALL drive iss_ready=0 when pending[iss_rd]==3 and iss_rd!=0; otherwise iss_ready=1 (no wrap-around).
REQ-021 SHALL ignore a decrement on a counter already at 0; the counter stays 0.
REQ-022 SHALL set busy_a=(pending[chk_ra]!=0) combinationally, with the same rule for busy_b; a query of x0 gives 0.
REQ-023 SHALL, as a result of REQ-013 and REQ-018, drop busy for a register in the cycle after the rf_wen write, when the register file already holds the new value.

Reset
REQ-024 SHALL, while rst=1 at a posedge, clear every pending counter and the output register, and drop any in-flight result.
REQ-025 SHALL produce rf_wen=0, rf_waddr=0, rf_wdata=0, busy_a=busy_b=0 and iss_ready=1 in the first cycle after reset.
REQ-026 SHALL keep exu_ready and lsu_ready following REQ-011 and REQ-012 during reset, with accepts discarded.

Configuration
REQ-027 SHALL, when YSYX_23060096_WBU_PERF_EN is defined, add the output commit_cnt out 64: a count of rf_wen=1 cycles that reset clears and that wraps at 2^64.
REQ-028 SHALL, when YSYX_23060096_WBU_PERF_EN is undefined, have neither the commit_cnt port nor its counter logic.

Structure
REQ-029 SHALL take the ADDR_WIDTH/DATA_WIDTH defaults and the counter width (2) from the shared ysyx_23060096_pkg constants.
REQ-030 SHALL place the pending counters and busy lookup in one sub-module, ysyx_23060096_scoreboard; arbitration and the output register stay in the top.

Verification
REQ-031 SHALL verify: issue rd=5; EXU accepts rd=5, data=0x12345678 at cycle N -> rf_wen=1, waddr=5, wdata=0x12345678 at N+1; busy for chk_ra=5 is 1 through N+1 and 0 at N+2.
REQ-032 SHALL verify: exu_valid and lsu_valid both 1 (rd 3 and 4) -> exu_ready=0; the LSU write to 4 comes first, then the EXU write to 3 one cycle later.
REQ-033 SHALL verify: issue rd=7 three times -> iss_ready=0 for rd=7; one writeback to 7 -> iss_ready=1; busy stays 1 until all three have written.
REQ-034 SHALL verify: LSU result rd=0, data=0xFFFFFFFF -> rf_wen stays 0; busy for chk_ra=0 is 0.
REQ-035 SHALL verify: issue rd=9 in the same cycle that rf_wen writes 9 with pending[9]=1 -> pending stays 1 and busy for 9 stays 1.
REQ-036 SHALL verify: rst=1 for one cycle mid-operation, with pending counters non-zero -> the next cycle gives rf_wen=0, all busy 0 and commit_cnt=0 (PERF_EN build).

Source files
------------

// File: rtl/ysyx_23060096_pkg.sv
// Shared constants for the writeback unit and its register scoreboard.
package ysyx_23060096_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned CNT_WIDTH      = 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

endpackage

// File: rtl/ysyx_23060096_scoreboard.sv
// Per-register pending-write counters and the combinational busy/full lookups.
module ysyx_23060096_scoreboard
    import ysyx_23060096_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_en,
    input  logic [ADDR_WIDTH-1:0] inc_addr,
    input  logic                  dec_en,
    input  logic [ADDR_WIDTH-1:0] dec_addr,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] chk_ra,
    input  logic [ADDR_WIDTH-1:0] chk_rb,
    output logic                  full_c,
    output logic                  busy_a_c,
    output logic                  busy_b_c
);

    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic [CNT_WIDTH-1:0] cnt_q [NREG];
    logic [CNT_WIDTH-1:0] cnt_d [NREG];
    logic [NREG-1:0]      inc_hot;
    logic [NREG-1:0]      dec_hot;

    // Entry 0 is pinned to zero so x0 never reads as busy or full.
    always_comb begin
        inc_hot = inc_en ? (NREG'(1) << inc_addr) : '0;
        dec_hot = dec_en ? (NREG'(1) << dec_addr) : '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        cnt_d[0] = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            case ({inc_hot[i], dec_hot[i]})
                2'b10: if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                2'b01: if (cnt_q[i] != '0)      cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign full_c   = (cnt_q[iss_rd] == CNT_MAX);
    assign busy_a_c = (cnt_q[chk_ra] != '0);
    assign busy_b_c = (cnt_q[chk_rb] != '0);

endmodule

// File: rtl/ysyx_23060096_wbu.sv
// Writeback unit: LSU/EXU arbitration, registered RF write port, scoreboard.
// Define YSYX_23060096_WBU_PERF_EN to add the commit_cnt performance counter.
module ysyx_23060096_wbu
    import ysyx_23060096_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] chk_ra,
    input  logic [ADDR_WIDTH-1:0] chk_rb,
    output logic                  busy_a,
    output logic                  busy_b
`ifdef YSYX_23060096_WBU_PERF_EN
    ,
    output logic [63:0]           commit_cnt
`endif
);

    logic                  res_valid;
    logic [ADDR_WIDTH-1:0] res_rd;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  wen_d;
    logic                  full_c;
    logic                  iss_fire;

    // LSU is always ready and has priority; EXU stalls while a load result is present.
    assign lsu_ready = 1'b1;
    assign exu_ready = !lsu_valid;
    assign iss_ready = !full_c;
    assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

    always_comb begin
        res_valid = lsu_valid || exu_valid;
        res_rd    = lsu_valid ? lsu_rd   : exu_rd;
        res_data  = lsu_valid ? lsu_data : exu_data;
        wen_d     = res_valid && (res_rd != '0);
    end

    // Address/data only move on a real write; x0 results are swallowed here.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= wen_d;
            if (wen_d) begin
                rf_waddr <= res_rd;
                rf_wdata <= res_data;
            end
        end
    end

    ysyx_23060096_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (iss_fire),
        .inc_addr (iss_rd),
        .dec_en   (rf_wen),
        .dec_addr (rf_waddr),
        .iss_rd   (iss_rd),
        .chk_ra   (chk_ra),
        .chk_rb   (chk_rb),
        .full_c   (full_c),
        .busy_a_c (busy_a),
        .busy_b_c (busy_b)
    );

`ifdef YSYX_23060096_WBU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt <= '0;
        end else if (rf_wen) begin
            commit_cnt <= commit_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060096_wbu.sv
// Directed bench for ysyx_23060096_wbu with a cycle-level reference model.
module tb_ysyx_23060096_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_ra, chk_rb;
    logic        busy_a, busy_b;
`ifdef YSYX_23060096_WBU_PERF_EN
    logic [63:0] commit_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_23060096_wbu dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .chk_ra    (chk_ra),
        .chk_rb    (chk_rb),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
`ifdef YSYX_23060096_WBU_PERF_EN
        ,
        .commit_cnt(commit_cnt)
`endif
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: outstanding-write counts per register and the expected write port.
    int              pend [32];
    bit              m_live = 1'b0;
    bit              m_wen;
    logic [4:0]      m_waddr;
    logic [31:0]     m_wdata;
    longint unsigned m_cnt;
    bit              do_inc, do_dec, have_res;
    logic [4:0]      res_rd;
    logic [31:0]     res_data;

    function automatic bit exp_iss_ready(input logic [4:0] rd);
        return !(rd != 0 && pend[rd] == 3);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
            m_live = 1'b1;
        end else begin
            do_inc   = iss_valid && exp_iss_ready(iss_rd) && iss_rd != 0;
            do_dec   = m_wen;
            have_res = lsu_valid || exu_valid;
            res_rd   = lsu_valid ? lsu_rd : exu_rd;
            res_data = lsu_valid ? lsu_data : exu_data;
            if (m_wen) m_cnt++;
            if (!(do_inc && do_dec && iss_rd == m_waddr)) begin
                if (do_dec && pend[m_waddr] > 0) pend[m_waddr]--;
                if (do_inc && pend[iss_rd] < 3) pend[iss_rd]++;
            end
            m_wen = have_res && res_rd != 0;
            if (m_wen) begin
                m_waddr = res_rd;
                m_wdata = res_data;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("rf_wen", rf_wen, m_wen);
            if (m_wen) begin
                check("rf_waddr", rf_waddr, m_waddr);
                check("rf_wdata", rf_wdata, m_wdata);
            end
            check("iss_ready", iss_ready, exp_iss_ready(iss_rd));
            check("busy_a", busy_a, chk_ra != 0 && pend[chk_ra] != 0);
            check("busy_b", busy_b, chk_rb != 0 && pend[chk_rb] != 0);
            check("exu_ready", exu_ready, !lsu_valid);
            check("lsu_ready", lsu_ready, 1'b1);
`ifdef YSYX_23060096_WBU_PERF_EN
            check("commit_cnt", commit_cnt, m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        iss_rd = '0; exu_rd = '0; lsu_rd = '0;
        exu_data = '0; lsu_data = '0;
        chk_ra = 5'd5; chk_rb = 5'd0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_wen", rf_wen, 1'b0);
        check("rst_waddr", rf_waddr, 5'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_iss_ready", iss_ready, 1'b1);

        // Basic issue -> EXU result -> writeback on register 5.
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        idle();
        @(negedge clk);
        check("r5_busy_issued", busy_a, 1'b1);
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234_5678;
        tick();
        idle();
        @(negedge clk);
        check("r5_wen", rf_wen, 1'b1);
        check("r5_waddr", rf_waddr, 5'd5);
        check("r5_wdata", rf_wdata, 32'h1234_5678);
        check("r5_busy_n1", busy_a, 1'b1);
        tick();
        @(negedge clk);
        check("r5_wen_n2", rf_wen, 1'b0);
        check("r5_busy_n2", busy_a, 1'b0);

        // Simultaneous LSU/EXU results: LSU goes first.
        iss_valid = 1'b1; iss_rd = 5'd3; tick();
        iss_rd = 5'd4; tick();
        idle();
        chk_ra = 5'd3; chk_rb = 5'd4;
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hAAAA_0003;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hBBBB_0004;
        @(negedge clk);
        check("arb_exu_ready", exu_ready, 1'b0);
        tick();
        lsu_valid = 1'b0;
        @(negedge clk);
        check("arb_first_addr", rf_waddr, 5'd4);
        check("arb_first_data", rf_wdata, 32'hBBBB_0004);
        check("arb_exu_ready_free", exu_ready, 1'b1);
        tick();
        idle();
        @(negedge clk);
        check("arb_second_addr", rf_waddr, 5'd3);
        check("arb_second_data", rf_wdata, 32'hAAAA_0003);
        tick();

        // Saturation of register 7 at three outstanding writes.
        chk_ra = 5'd7; chk_rb = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick(); tick(); tick();
        idle();
        @(negedge clk);
        check("r7_full", iss_ready, 1'b0);
        check("r7_busy", busy_a, 1'b1);
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h0000_0701;
        tick();
        idle();
        @(negedge clk);
        check("r7_full_during_wb", iss_ready, 1'b0);
        tick();
        @(negedge clk);
        check("r7_ready_after_wb", iss_ready, 1'b1);
        check("r7_busy_2left", busy_a, 1'b1);
        exu_valid = 1'b1; exu_data = 32'h0000_0702;
        tick();
        exu_data = 32'h0000_0703;
        tick();
        idle();
        @(negedge clk);
        check("r7_busy_1left", busy_a, 1'b1);
        tick();
        @(negedge clk);
        check("r7_idle", busy_a, 1'b0);

        // Load to x0 is accepted but never written.
        chk_ra = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        tick();
        idle();
        @(negedge clk);
        check("x0_wen", rf_wen, 1'b0);
        check("x0_busy", busy_a, 1'b0);

        // Issue and writeback of register 9 in the same cycle.
        chk_ra = 5'd9; chk_rb = 5'd12;
        iss_valid = 1'b1; iss_rd = 5'd9; tick();
        idle();
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h0000_0009;
        tick();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd9;
        @(negedge clk);
        check("r9_wen", rf_wen, 1'b1);
        tick();
        idle();
        @(negedge clk);
        check("r9_still_busy", busy_a, 1'b1);

        // Reset mid-flight with pending counters and a write in progress.
        iss_valid = 1'b1; iss_rd = 5'd12; tick();
        idle();
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h0000_0099;
        tick();
        rst = 1'b1;
        exu_rd = 5'd12; exu_data = 32'h0000_00CC;
        @(negedge clk);
        check("pre_rst_wen", rf_wen, 1'b1);
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("post_rst_wen", rf_wen, 1'b0);
        check("post_rst_busy9", busy_a, 1'b0);
        check("post_rst_busy12", busy_b, 1'b0);
`ifdef YSYX_23060096_WBU_PERF_EN
        check("post_rst_commit", commit_cnt, 64'd0);
`endif
        // Write to a register with no pending count: counter stays at zero.
        exu_valid = 1'b1; exu_rd = 5'd12; exu_data = 32'h0000_0C0C;
        tick();
        idle();
        @(negedge clk);
        check("late_wen", rf_wen, 1'b1);
        check("late_wdata", rf_wdata, 32'h0000_0C0C);
        tick();
        @(negedge clk);
        check("late_busy12", busy_b, 1'b0);
`ifdef YSYX_23060096_WBU_PERF_EN
        check("late_commit", commit_cnt, 64'd1);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
